// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, fixed-latency memory between the
// instruction-fetch requester and the data requester of the unified-memory
// 5-stage MIPS pipeline. It issues one access at a time, returns read data with
// a one-cycle valid pulse, and generates the PC/IF-ID and full-pipeline stalls.
// Optional feature: define ARB_RR_EN for round-robin arbitration between
// simultaneous requests. The default is fixed data-over-fetch priority.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_rd,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_pipe
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          mem_en_nxt, mem_we_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt;
  logic [DW-1:0] if_rdata_nxt, d_rdata_nxt;
  logic          if_valid_nxt, d_valid_nxt;

  logic d_req;
  logic d_pend;
  logic i_pend;
  logic d_first;
  logic issue_d;
  logic issue_i;

  // A requester whose valid is showing this cycle still holds its request;
  // it is not a new request and must not be re-issued.
  assign d_req  = d_rd | d_wr;
  assign d_pend = d_req & ~d_valid;
  assign i_pend = if_req & ~if_valid;

  assign stall_pipe = d_req & ~d_valid;
  assign stall_if   = (if_req & ~if_valid) | stall_pipe;

`ifdef ARB_RR_EN
  logic last_d;

  // Remember who was granted last so simultaneous requests alternate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (issue_d) begin
      last_d <= 1'b1;
    end else if (issue_i) begin
      last_d <= 1'b0;
    end
  end

  assign d_first = ~last_d;
`else
  assign d_first = 1'b1;
`endif

  // Next-state logic: issue, latency countdown, completion and back-to-back issue.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    mem_en_nxt    = mem_en;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    d_rdata_nxt   = d_rdata;
    if_valid_nxt  = 1'b0;
    d_valid_nxt   = 1'b0;
    issue_d       = 1'b0;
    issue_i       = 1'b0;

    unique case (state)
      IDLE: begin
        if (d_pend && (d_first || !i_pend)) begin
          issue_d = 1'b1;
        end else if (i_pend) begin
          issue_i = 1'b1;
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          // Completion: the served requester is masked by only looking at the other.
          state_nxt  = IDLE;
          mem_en_nxt = 1'b0;
          mem_we_nxt = 1'b0;
          if (state == BUSY_I) begin
            if_valid_nxt = 1'b1;
            if_rdata_nxt = mem_rdata;
            issue_d      = d_pend;
          end else begin
            d_valid_nxt = 1'b1;
            if (!mem_we) begin
              d_rdata_nxt = mem_rdata;
            end
            issue_i = i_pend;
          end
        end
      end
      default: begin
        state_nxt  = IDLE;
        mem_en_nxt = 1'b0;
        mem_we_nxt = 1'b0;
      end
    endcase

    if (issue_d) begin
      state_nxt     = BUSY_D;
      cnt_nxt       = CNT_INIT;
      mem_en_nxt    = 1'b1;
      mem_we_nxt    = d_wr;
      mem_addr_nxt  = d_addr;
      mem_wdata_nxt = d_wdata;
    end else if (issue_i) begin
      state_nxt    = BUSY_I;
      cnt_nxt      = CNT_INIT;
      mem_en_nxt   = 1'b1;
      mem_we_nxt   = 1'b0;
      mem_addr_nxt = if_addr;
    end
  end

  // State, counter, memory-port and read-data registers; reset drops any access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_rdata  <= if_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      if_valid  <= if_valid_nxt;
      d_valid   <= d_valid_nxt;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, fixed-latency memory between the pipeline's instruction-fetch requester (IF stage) and data requester (MEM stage), for the unified-memory build of the 5-stage MIPS pipeline. It sequences each access with a small FSM and a latency counter, and returns read data with a one-cycle valid pulse. It also generates the stall signals that freeze the PC, IF/ID and the full pipeline while an access is outstanding.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 2, memory access latency in cycles, ≥1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched instruction
- if_valid  out  1  one-cycle fetch completion pulse
- d_rd  in  1  data read request; held until d_valid
- d_wr  in  1  data write request; held until d_valid
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_rdata  out  DW  read data
- d_valid  out  1  one-cycle data completion pulse (reads and writes)
- mem_en  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid in the last access cycle
- stall_if  out  1  hold PC and IF/ID
- stall_pipe  out  1  freeze all pipeline registers

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D. The state, latency counter cnt, mem_* and *_rdata are registered.
- Data request: d_rd|d_wr. If both d_rd and d_wr are high, the request is a write.
- **IDLE**, at a clock edge:
  - If a request is pending, pick the winner and latch its address, wdata and we into the mem_* registers.
  - Set mem_en=1 and cnt=MEM_LAT-1.
  - Go to BUSY_D or BUSY_I.
- **BUSY_x**, at each edge while cnt≠0: decrement cnt. The mem_* outputs stay constant.
- **BUSY_x**, at the edge where cnt==0 (completion):
  - On a read, capture mem_rdata into x_rdata.
  - Pulse x_valid for the following cycle.
  - On a write, d_rdata is unchanged.
- Back-to-back at the completion edge:
  - The just-served requester is masked, because its request is still high in that cycle.
  - If the other requester is pending, issue it immediately (same action as IDLE issue).
  - Otherwise set mem_en=0, mem_we=0 and go to IDLE.
- Arbitration when both requesters are pending in IDLE: data wins (the older instruction), unless modified per Configuration.
- Requesters must hold address and data stable until valid. The arbiter only uses its latched copy.
- stall_pipe = (d_rd|d_wr) & ~d_valid. This is combinational.
- stall_if = (if_req & ~if_valid) | stall_pipe. This is combinational.
- A request that drops before completion does not abort the access. The access completes and valid still pulses.

## Timing
- Latency from request sampled in IDLE to valid high is MEM_LAT+1 cycles. mem_en is high for exactly MEM_LAT cycles per access.
- Back-to-back accesses are issued with 0 idle cycles between them. A waiting requester waits at most MEM_LAT cycles for the current access to finish.
- Reset values: state=IDLE, cnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, d_rdata=0, if_valid=0, d_valid=0. The stall outputs follow the combinational equations above.
- Reset asserted mid-access: the access is dropped immediately, no valid is produced, and mem_en goes to 0 asynchronously.
- MEM_LAT=1: cnt stays 0, and every BUSY cycle is a completion cycle.

## Configuration
- ARB_RR_EN defined: round-robin among simultaneous requests. A 1-bit last_served register (reset to fetch) selects the requester not served last.
  - This prevents a long run of loads/stores from starving fetch.
  - The completion-edge masking rule is unchanged.
- ARB_RR_EN undefined: fixed data-over-fetch priority, and last_served is not built.

## Test plan
- Fetch only, MEM_LAT=2, if_addr=0x10, mem_rdata=0x8C220004 in the last access cycle:
  - mem_en high for 2 cycles, then if_valid pulses in cycle 3 with if_rdata=0x8C220004.
  - stall_if is high from request until if_valid.
- Data write, d_addr=0x40, d_wdata=0xDEADBEEF:
  - mem_we=1 and mem_addr=0x40 for 2 cycles, then d_valid pulses.
  - d_rdata is unchanged.
  - stall_pipe and stall_if are high until d_valid.
- Simultaneous if_req and d_rd in IDLE, without ARB_RR_EN:
  - Data is served first, fetch issues at the data completion edge with no idle cycle, and if_valid arrives 2 cycles after d_valid.
- With ARB_RR_EN, d_rd held continuously over 3 requests while if_req is high:
  - Grants alternate D, I, D, so fetch completes before the second data access.
- rst pulsed in the 2nd BUSY_D cycle:
  - mem_en=0 immediately and no d_valid is produced.
  - After release, the still-held d_rd is re-issued and completes MEM_LAT+1 cycles later.
